// File: rtl/alu_pkg.sv
// Shared ALU definitions: widths, one-hot op bit indices,
// the request bundle and a one-hot legality helper.
package alu_pkg;

    localparam int XLEN   = 64;
    localparam int CTRL_W = 17;
    localparam int TAG_W  = 4;

    localparam int OP_ADD  = 0;
    localparam int OP_SUB  = 1;
    localparam int OP_SLT  = 2;
    localparam int OP_SLTU = 3;
    localparam int OP_AND  = 4;
    localparam int OP_XOR  = 5;
    localparam int OP_OR   = 6;
    localparam int OP_SLL  = 7;
    localparam int OP_SRL  = 8;
    localparam int OP_SRA  = 9;
    localparam int OP_LUI  = 10;
    localparam int OP_BEQ  = 11;
    localparam int OP_BNE  = 12;
    localparam int OP_BLT  = 13;
    localparam int OP_BGE  = 14;
    localparam int OP_BLTU = 15;
    localparam int OP_BGEU = 16;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [XLEN-1:0]   sr1;
        logic [XLEN-1:0]   sr2;
        logic [TAG_W-1:0]  tag;
    } alu_req_t;

    // Exactly one bit set: nonzero and clearing the lowest set bit leaves 0.
    function automatic logic is_onehot(input logic [CTRL_W-1:0] c);
        return (c != '0) && ((c & (c - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/alu_share_arb_if.sv
// Bus bundle for alu_share_arb: two requesters, shared ALU port,
// response register and grant counters. slave = arbiter side.
interface alu_share_arb_if;
    import alu_pkg::*;

    logic              req0_valid;
    logic              req0_ready;
    logic [CTRL_W-1:0] req0_ctrl;
    logic [XLEN-1:0]   req0_sr1;
    logic [XLEN-1:0]   req0_sr2;
    logic [TAG_W-1:0]  req0_tag;

    logic              req1_valid;
    logic              req1_ready;
    logic [CTRL_W-1:0] req1_ctrl;
    logic [XLEN-1:0]   req1_sr1;
    logic [XLEN-1:0]   req1_sr2;
    logic [TAG_W-1:0]  req1_tag;

    logic [CTRL_W-1:0] alu_ctrl;
    logic [XLEN-1:0]   alu_sr1;
    logic [XLEN-1:0]   alu_sr2;
    logic [XLEN-1:0]   alu_res;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [XLEN-1:0]   rsp_res;
    logic [TAG_W-1:0]  rsp_tag;
    logic              rsp_src;
    logic              rsp_err;

    logic [31:0]       gnt_cnt0;
    logic [31:0]       gnt_cnt1;

    modport slave (
        input  req0_valid, req0_ctrl, req0_sr1, req0_sr2, req0_tag,
        output req0_ready,
        input  req1_valid, req1_ctrl, req1_sr1, req1_sr2, req1_tag,
        output req1_ready,
        output alu_ctrl, alu_sr1, alu_sr2,
        input  alu_res,
        output rsp_valid, rsp_res, rsp_tag, rsp_src, rsp_err,
        input  rsp_ready,
        output gnt_cnt0, gnt_cnt1
    );

    modport master (
        output req0_valid, req0_ctrl, req0_sr1, req0_sr2, req0_tag,
        input  req0_ready,
        output req1_valid, req1_ctrl, req1_sr1, req1_sr2, req1_tag,
        input  req1_ready,
        input  alu_ctrl, alu_sr1, alu_sr2,
        output alu_res,
        input  rsp_valid, rsp_res, rsp_tag, rsp_src, rsp_err,
        output rsp_ready,
        input  gnt_cnt0, gnt_cnt1
    );

endinterface

// File: rtl/alu_share_arb_rr_arb2.sv
// Two-way arbiter holding the last-granted flop.
// Ports: clk, rst, req[1:0], advance (grant taken), mode (1=fixed), gnt[1:0].
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    input  logic       mode,
    output logic [1:0] gnt
);

    logic last_gnt;

    // On a tie the requester that did not win last goes; fixed mode favours req0.
    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (mode || last_gnt) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // Reset to 1 so req0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt <= 1'b1;
        end else if (advance) begin
            last_gnt <= gnt[1];
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one external combinational ALU between two requesters and
// returns each result through a one-entry valid/ready response register.
// Ports: clk, rst (sync, active-high), bus (alu_share_arb_if.slave).
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int ARB_MODE = 0
) (
    input  logic            clk,
    input  logic            rst,
    alu_share_arb_if.slave  bus
);

    logic [1:0] req;
    logic [1:0] gnt;
    logic       can_accept;
    logic       accept;
    logic       legal;
    alu_req_t   r0;
    alu_req_t   r1;
    alu_req_t   sel;

    assign r0 = {bus.req0_ctrl, bus.req0_sr1, bus.req0_sr2, bus.req0_tag};
    assign r1 = {bus.req1_ctrl, bus.req1_sr1, bus.req1_sr2, bus.req1_tag};
    assign req = {bus.req1_valid, bus.req0_valid};

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .advance (accept),
        .mode    (ARB_MODE != 0),
        .gnt     (gnt)
    );

    // The register can take a new result if empty or being drained now.
    assign can_accept     = ~bus.rsp_valid | bus.rsp_ready;
    assign bus.req0_ready = gnt[0] & can_accept;
    assign bus.req1_ready = gnt[1] & can_accept;
    assign accept         = (gnt[0] | gnt[1]) & can_accept;

    // No grant leaves the ALU inputs at zero.
    always_comb begin
        sel = '0;
        unique case (1'b1)
            gnt[1]:  sel = r1;
            gnt[0]:  sel = r0;
            default: sel = '0;
        endcase
    end

    assign bus.alu_ctrl = sel.ctrl;
    assign bus.alu_sr1  = sel.sr1;
    assign bus.alu_sr2  = sel.sr2;
    assign legal        = is_onehot(sel.ctrl);

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_res   <= '0;
            bus.rsp_tag   <= '0;
            bus.rsp_src   <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.gnt_cnt0  <= '0;
            bus.gnt_cnt1  <= '0;
        end else if (accept) begin
            // A malformed op still completes, flagged, with a zero result.
            bus.rsp_valid <= 1'b1;
            bus.rsp_res   <= legal ? bus.alu_res : '0;
            bus.rsp_tag   <= sel.tag;
            bus.rsp_src   <= gnt[1];
            bus.rsp_err   <= ~legal;
            if (gnt[0]) begin
                bus.gnt_cnt0 <= bus.gnt_cnt0 + 32'd1;
            end
            if (gnt[1]) begin
                bus.gnt_cnt1 <= bus.gnt_cnt1 + 32'd1;
            end
        end else if (bus.rsp_ready) begin
            // Drain only clears valid; data fields hold.
            bus.rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb: round-robin and fixed-priority
// instances driven by directed steps then random traffic vs a reference model.
module tb_alu_share_arb;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_share_arb_if b0 ();
    alu_share_arb_if b1 ();

    alu_share_arb #(.ARB_MODE(0)) u0 (.clk(clk), .rst(rst), .bus(b0));
    alu_share_arb #(.ARB_MODE(1)) u1 (.clk(clk), .rst(rst), .bus(b1));

    // Stimulus per dut [d] and requester [r]
    logic              v  [2][2];
    logic [CTRL_W-1:0] c  [2][2];
    logic [XLEN-1:0]   sa [2][2];
    logic [XLEN-1:0]   sb [2][2];
    logic [TAG_W-1:0]  tg [2][2];
    logic              rr [2];

    // Observed outputs
    logic              ordy [2][2];
    logic              ov   [2];
    logic [XLEN-1:0]   ores [2];
    logic [TAG_W-1:0]  otag [2];
    logic              osrc [2];
    logic              oerr [2];
    logic [31:0]       oc0  [2];
    logic [31:0]       oc1  [2];

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural ALU; a malformed ctrl yields a nonzero junk value.
    function automatic logic [63:0] alu_fn(input logic [16:0] ct,
                                           input logic [63:0] x,
                                           input logic [63:0] y);
        if ($countones(ct) != 1) return 64'hDEAD_BEEF_0BAD_F00D;
        case (1'b1)
            ct[OP_ADD]:  return x + y;
            ct[OP_SUB]:  return x - y;
            ct[OP_SLT]:  return {63'd0, $signed(x) < $signed(y)};
            ct[OP_SLTU]: return {63'd0, x < y};
            ct[OP_AND]:  return x & y;
            ct[OP_XOR]:  return x ^ y;
            ct[OP_OR]:   return x | y;
            ct[OP_SLL]:  return x << y[5:0];
            ct[OP_SRL]:  return x >> y[5:0];
            ct[OP_SRA]:  return $signed(x) >>> y[5:0];
            ct[OP_LUI]:  return y;
            ct[OP_BEQ]:  return {63'd0, x == y};
            ct[OP_BNE]:  return {63'd0, x != y};
            ct[OP_BLT]:  return {63'd0, $signed(x) < $signed(y)};
            ct[OP_BGE]:  return {63'd0, $signed(x) >= $signed(y)};
            ct[OP_BLTU]: return {63'd0, x < y};
            ct[OP_BGEU]: return {63'd0, x >= y};
            default:     return 64'd0;
        endcase
    endfunction

    assign b0.alu_res = alu_fn(b0.alu_ctrl, b0.alu_sr1, b0.alu_sr2);
    assign b1.alu_res = alu_fn(b1.alu_ctrl, b1.alu_sr1, b1.alu_sr2);

    assign b0.req0_valid = v[0][0];
    assign b0.req0_ctrl  = c[0][0];
    assign b0.req0_sr1   = sa[0][0];
    assign b0.req0_sr2   = sb[0][0];
    assign b0.req0_tag   = tg[0][0];
    assign b0.req1_valid = v[0][1];
    assign b0.req1_ctrl  = c[0][1];
    assign b0.req1_sr1   = sa[0][1];
    assign b0.req1_sr2   = sb[0][1];
    assign b0.req1_tag   = tg[0][1];
    assign b0.rsp_ready  = rr[0];
    assign b1.req0_valid = v[1][0];
    assign b1.req0_ctrl  = c[1][0];
    assign b1.req0_sr1   = sa[1][0];
    assign b1.req0_sr2   = sb[1][0];
    assign b1.req0_tag   = tg[1][0];
    assign b1.req1_valid = v[1][1];
    assign b1.req1_ctrl  = c[1][1];
    assign b1.req1_sr1   = sa[1][1];
    assign b1.req1_sr2   = sb[1][1];
    assign b1.req1_tag   = tg[1][1];
    assign b1.rsp_ready  = rr[1];

    assign ordy[0][0] = b0.req0_ready;
    assign ordy[0][1] = b0.req1_ready;
    assign ordy[1][0] = b1.req0_ready;
    assign ordy[1][1] = b1.req1_ready;
    assign ov[0]   = b0.rsp_valid;
    assign ov[1]   = b1.rsp_valid;
    assign ores[0] = b0.rsp_res;
    assign ores[1] = b1.rsp_res;
    assign otag[0] = b0.rsp_tag;
    assign otag[1] = b1.rsp_tag;
    assign osrc[0] = b0.rsp_src;
    assign osrc[1] = b1.rsp_src;
    assign oerr[0] = b0.rsp_err;
    assign oerr[1] = b1.rsp_err;
    assign oc0[0]  = b0.gnt_cnt0;
    assign oc0[1]  = b1.gnt_cnt0;
    assign oc1[0]  = b0.gnt_cnt1;
    assign oc1[1]  = b1.gnt_cnt1;

    // Reference model state
    logic            mv    [2];
    logic [63:0]     mres  [2];
    logic [3:0]      mtag  [2];
    logic            msrc  [2];
    logic            merr  [2];
    logic [31:0]     mc0   [2];
    logic [31:0]     mc1   [2];
    int              mlast [2];
    logic            acc   [2];
    int              accsrc[2];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mv[d] = 1'b0; mres[d] = '0; mtag[d] = '0;
            msrc[d] = 1'b0; merr[d] = 1'b0;
            mc0[d] = '0; mc1[d] = '0;
            mlast[d] = 1; acc[d] = 1'b0; accsrc[d] = 0;
        end
    endtask

    task automatic check_out();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d_rsp_valid", d), 64'(ov[d]), 64'(mv[d]));
            chk($sformatf("d%0d_rsp_res", d), ores[d], mres[d]);
            chk($sformatf("d%0d_rsp_tag", d), 64'(otag[d]), 64'(mtag[d]));
            chk($sformatf("d%0d_rsp_src", d), 64'(osrc[d]), 64'(msrc[d]));
            chk($sformatf("d%0d_rsp_err", d), 64'(oerr[d]), 64'(merr[d]));
            chk($sformatf("d%0d_gnt_cnt0", d), 64'(oc0[d]), 64'(mc0[d]));
            chk($sformatf("d%0d_gnt_cnt1", d), 64'(oc1[d]), 64'(mc1[d]));
        end
    endtask

    // One clock: check readys, clock edge, update model, check outputs.
    // dut 0 is round-robin, dut 1 is fixed priority.
    task automatic step();
        int   g   [2];
        logic can [2];
        int   r;
        #1;
        for (int d = 0; d < 2; d++) begin
            can[d] = !mv[d] || rr[d];
            g[d] = -1;
            if (v[d][0] && v[d][1]) g[d] = (d == 1 || mlast[d] == 1) ? 0 : 1;
            else if (v[d][0]) g[d] = 0;
            else if (v[d][1]) g[d] = 1;
            chk($sformatf("d%0d_req0_ready", d), 64'(ordy[d][0]),
                64'(g[d] == 0 && can[d]));
            chk($sformatf("d%0d_req1_ready", d), 64'(ordy[d][1]),
                64'(g[d] == 1 && can[d]));
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            acc[d] = 1'b0;
            if (g[d] >= 0 && can[d]) begin
                r = g[d];
                mv[d]   = 1'b1;
                merr[d] = ($countones(c[d][r]) != 1);
                mres[d] = merr[d] ? 64'd0 : alu_fn(c[d][r], sa[d][r], sb[d][r]);
                mtag[d] = tg[d][r];
                msrc[d] = (r == 1);
                if (r == 0) mc0[d] = mc0[d] + 1;
                else mc1[d] = mc1[d] + 1;
                mlast[d] = r;
                acc[d] = 1'b1;
                accsrc[d] = r;
            end else if (rr[d]) begin
                mv[d] = 1'b0;
            end
        end
        @(negedge clk);
        check_out();
    endtask

    task automatic new_op(input int d, input int r);
        if ($urandom_range(0, 9) == 0) c[d][r] = 17'($urandom);
        else c[d][r] = 17'(1) << $urandom_range(0, 16);
        sa[d][r] = {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0) sb[d][r] = 64'($urandom_range(0, 70));
        else sb[d][r] = {$urandom, $urandom};
        tg[d][r] = 4'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_out();
    endtask

    logic [63:0] saved;

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            rr[d] = 1'b0;
            for (int r = 0; r < 2; r++) begin
                v[d][r] = 1'b0; c[d][r] = '0;
                sa[d][r] = '0; sb[d][r] = '0; tg[d][r] = '0;
            end
        end
        model_reset();
        @(negedge clk);
        do_reset();

        // Both valid after reset: req0 first; then ADD 5+7
        c[0][0] = 17'(1) << OP_ADD; sa[0][0] = 64'd5; sb[0][0] = 64'd7;
        tg[0][0] = 4'd3; v[0][0] = 1'b1;
        c[0][1] = 17'(1) << OP_SUB; sa[0][1] = 64'd100; sb[0][1] = 64'd1;
        tg[0][1] = 4'd9; v[0][1] = 1'b1;
        rr[0] = 1'b1;
        #1;
        chk("t1_req0_ready_first", 64'(ordy[0][0]), 64'd1);
        chk("t1_req1_ready_first", 64'(ordy[0][1]), 64'd0);
        step();
        chk("t2_rsp_valid", 64'(ov[0]), 64'd1);
        chk("t2_rsp_res", ores[0], 64'd12);
        chk("t2_rsp_tag", 64'(otag[0]), 64'd3);
        chk("t2_rsp_src", 64'(osrc[0]), 64'd0);
        chk("t2_rsp_err", 64'(oerr[0]), 64'd0);
        chk("t2_gnt_cnt0", 64'(oc0[0]), 64'd1);
        new_op(0, 0);

        // Round-robin alternation from a fresh reset
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("t3_src_%0d", i), 64'(osrc[0]), 64'(i % 2));
            chk($sformatf("t3_valid_%0d", i), 64'(ov[0]), 64'd1);
            if (acc[0]) new_op(0, accsrc[0]);
        end
        chk("t3_gnt_cnt0", 64'(oc0[0]), 64'd2);
        chk("t3_gnt_cnt1", 64'(oc1[0]), 64'd2);

        // Backpressure holds everything
        rr[0] = 1'b0;
        saved = ores[0];
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("t4_ready0_%0d", i), 64'(ordy[0][0]), 64'd0);
            chk($sformatf("t4_ready1_%0d", i), 64'(ordy[0][1]), 64'd0);
            step();
            chk($sformatf("t4_res_held_%0d", i), ores[0], saved);
            chk($sformatf("t4_valid_%0d", i), 64'(ov[0]), 64'd1);
        end
        rr[0] = 1'b1;
        step();
        chk("t4_release_accept", 64'(acc[0]), 64'd1);
        chk("t4_release_valid", 64'(ov[0]), 64'd1);

        // Malformed ctrl on req1
        do_reset();
        v[0][0] = 1'b0;
        c[0][1] = 17'h00003; sa[0][1] = 64'd9; sb[0][1] = 64'd4;
        tg[0][1] = 4'd5; v[0][1] = 1'b1;
        step();
        chk("t5_res_zero", ores[0], 64'd0);
        chk("t5_err", 64'(oerr[0]), 64'd1);
        chk("t5_src", 64'(osrc[0]), 64'd1);
        c[0][1] = 17'h00000;
        step();
        chk("t5_err_zero_ctrl", 64'(oerr[0]), 64'd1);
        chk("t5_res_zero_ctrl", ores[0], 64'd0);
        v[0][1] = 1'b0;

        // Fixed priority instance
        new_op(1, 0); new_op(1, 1);
        v[1][0] = 1'b1; v[1][1] = 1'b1; rr[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("t6_src_%0d", i), 64'(osrc[1]), 64'd0);
            if (acc[1]) new_op(1, accsrc[1]);
        end
        chk("t6_gnt_cnt0", 64'(oc0[1]), 64'd3);
        chk("t6_gnt_cnt1", 64'(oc1[1]), 64'd0);

        // Reset while a response is pending
        chk("t6_pre_rst_valid", 64'(ov[1]), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk("t6_rst_valid", 64'(ov[1]), 64'd0);
        check_out();

        // Random traffic on both instances
        for (int n = 0; n < 400; n++) begin
            for (int d = 0; d < 2; d++) rr[d] = ($urandom_range(0, 3) != 0);
            step();
            for (int d = 0; d < 2; d++) begin
                for (int r = 0; r < 2; r++) begin
                    if (acc[d] && accsrc[d] == r) begin
                        if ($urandom_range(0, 1) == 1) new_op(d, r);
                        else v[d][r] = 1'b0;
                    end else if (!v[d][r] && $urandom_range(0, 2) == 0) begin
                        new_op(d, r);
                        v[d][r] = 1'b1;
                    end
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
